// File: rtl/acq_wr_monitor.sv
`default_nettype none
// ============================================================================
// Module   : acq_wr_monitor
// Purpose  : Cross-checks AXI write-beat sample counts against source sample
//            counts per acquisition channel around a trigger window.
// Revision : 1.0
// ============================================================================
module acq_wr_monitor #(
    parameter int NUM_CH = 2,
    parameter int DW     = 64,
    parameter int AW     = 32,
    parameter int CW     = 32,
    parameter int QUIET  = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic                   trig_i,
    input  logic [CW-1:0]          post_len_i,
    input  logic [NUM_CH-1:0]      axi_awvalid_i,
    input  logic [NUM_CH-1:0]      axi_awready_i,
    input  logic [NUM_CH*AW-1:0]   axi_awaddr_i,
    input  logic [NUM_CH-1:0]      axi_wvalid_i,
    input  logic [NUM_CH-1:0]      axi_wready_i,
    input  logic [NUM_CH*DW/8-1:0] axi_wstrb_i,
    input  logic [NUM_CH-1:0]      smp_we_i,
    output logic [NUM_CH*CW-1:0]   axi_cnt_o,
    output logic [NUM_CH*CW-1:0]   smp_cnt_o,
    output logic [NUM_CH*CW-1:0]   trig_cnt_o,
    output logic [NUM_CH*AW-1:0]   trig_addr_o,
    output logic [NUM_CH-1:0]      err_strb_o,
    output logic [NUM_CH-1:0]      err_cnt_o,
    output logic [2:0]             state_o,
    output logic                   done_o
);

    localparam int c_L    = DW / 16;
    localparam int c_SW   = DW / 8;
    localparam int c_KW   = $clog2(c_L + 1);
    localparam int c_IW   = $clog2(QUIET + 1);
    localparam int c_SUMW = CW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [NUM_CH*CW-1:0]   r_axi_cnt, r_smp_cnt, r_trig_cnt;
    logic [NUM_CH*AW-1:0]   r_aw_addr, r_trig_addr;
    logic [NUM_CH-1:0]      r_err_strb, r_err_cnt;
    logic [c_IW-1:0]        r_idle;
    logic                   r_done;

    logic [NUM_CH*CW-1:0]   w_axi_nxt, w_smp_nxt;
    logic [NUM_CH*AW-1:0]   w_aw_nxt;
    logic [NUM_CH-1:0]      w_beat, w_bad;
    logic                   w_active, w_rest;

    assign w_active = (r_state == S_ARMED) || (r_state == S_POST) || (r_state == S_CHECK);
    assign w_rest   = (r_state == S_IDLE) || (r_state == S_DONE);

    // Legal strobe for k samples: exactly the low 2k byte lanes set.
    function automatic logic [c_SW-1:0] lane_mask(input int k);
        logic [c_SW-1:0] m;
        for (int b = 0; b < c_SW; b++) m[b] = (b < 2 * k);
        return m;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [c_SW-1:0]   w_strb;
        logic [c_KW-1:0]   w_k;
        logic              w_legal;
        logic [c_SUMW-1:0] w_axi_sum, w_smp_sum;

        assign w_strb = axi_wstrb_i[c*c_SW +: c_SW];

        always_comb begin
            w_k     = '0;
            w_legal = 1'b0;
            for (int k = 0; k <= c_L; k++) begin
                if (w_strb == lane_mask(k)) begin
                    w_k     = c_KW'(k);
                    w_legal = 1'b1;
                end
            end
        end

        assign w_beat[c]  = axi_wvalid_i[c] & axi_wready_i[c];
        assign w_bad[c]   = w_beat[c] & ~w_legal;
        assign w_axi_sum  = {1'b0, r_axi_cnt[c*CW +: CW]} +
                            ((w_beat[c] && w_active) ? c_SUMW'(w_k) : '0);
        assign w_smp_sum  = {1'b0, r_smp_cnt[c*CW +: CW]} +
                            c_SUMW'(smp_we_i[c] & w_active);
        // Carry-out means the sum passed 2^CW-1: pin at all-ones.
        assign w_axi_nxt[c*CW +: CW] = w_axi_sum[CW] ? '1 : w_axi_sum[CW-1:0];
        assign w_smp_nxt[c*CW +: CW] = w_smp_sum[CW] ? '1 : w_smp_sum[CW-1:0];
        assign w_aw_nxt[c*AW +: AW]  = (axi_awvalid_i[c] & axi_awready_i[c]) ?
                                       axi_awaddr_i[c*AW +: AW] : r_aw_addr[c*AW +: AW];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_axi_cnt   <= '0;
            r_smp_cnt   <= '0;
            r_trig_cnt  <= '0;
            r_aw_addr   <= '0;
            r_trig_addr <= '0;
            r_err_strb  <= '0;
            r_err_cnt   <= '0;
            r_idle      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_aw_addr <= clear_i ? '0 : w_aw_nxt;
            if (clear_i || (w_rest && start_i)) begin
                r_axi_cnt   <= '0;
                r_smp_cnt   <= '0;
                r_trig_cnt  <= '0;
                r_trig_addr <= '0;
                r_err_strb  <= '0;
                r_err_cnt   <= '0;
                r_idle      <= '0;
                r_done      <= 1'b0;
                r_state     <= clear_i ? S_IDLE : S_ARMED;
            end else begin
                if (w_active) begin
                    r_axi_cnt  <= w_axi_nxt;
                    r_smp_cnt  <= w_smp_nxt;
                    r_err_strb <= r_err_strb | w_bad;
                end
                case (r_state)
                    S_ARMED: begin
                        // Snapshots take the post-update values of this very cycle.
                        if (trig_i) begin
                            r_trig_cnt  <= w_axi_nxt;
                            r_trig_addr <= w_aw_nxt;
                            r_state     <= S_POST;
                        end
                    end
                    S_POST: begin
                        r_idle <= '0;
                        if ((r_axi_cnt[CW-1:0] - r_trig_cnt[CW-1:0]) >= post_len_i)
                            r_state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (|w_beat) begin
                            r_idle <= '0;
                        end else begin
                            r_idle <= r_idle + c_IW'(1);
                            if (r_idle == c_IW'(QUIET - 1)) begin
                                for (int c = 0; c < NUM_CH; c++)
                                    r_err_cnt[c] <= (w_axi_nxt[c*CW +: CW] != w_smp_nxt[c*CW +: CW]);
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_IDLE, S_DONE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign axi_cnt_o   = r_axi_cnt;
    assign smp_cnt_o   = r_smp_cnt;
    assign trig_cnt_o  = r_trig_cnt;
    assign trig_addr_o = r_trig_addr;
    assign err_strb_o  = r_err_strb;
    assign err_cnt_o   = r_err_cnt;
    assign state_o     = r_state;
    assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_acq_wr_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_acq_wr_monitor
// Purpose  : Self-checking bench: directed vector table, hand sequences and a
//            randomized run against a rule-level reference model.
// Revision : 1.0
// ============================================================================
module tb_acq_wr_monitor;

    localparam int NC = 2;
    localparam int SW = 8;
    localparam int QT = 16;
    localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstn, start, clear, trig;
    logic [31:0] post_len;
    logic [1:0]  awv, awr, wv, wr, swe;
    logic [63:0] awaddr;
    logic [15:0] wstrb;

    logic [63:0] axi_cnt, smp_cnt, trig_cnt, trig_addr;
    logic [1:0]  err_strb, err_cnt;
    logic [2:0]  state;
    logic        done;

    logic       s4_start, s4_wv;
    logic [7:0] s4_strb;
    logic [3:0] a4_axi, a4_smp, a4_trig;
    logic [31:0] a4_taddr;
    logic       a4_estrb, a4_ecnt, a4_done;
    logic [2:0] a4_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    acq_wr_monitor #(.NUM_CH(2), .DW(64), .AW(32), .CW(32), .QUIET(QT)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .clear_i(clear), .trig_i(trig),
        .post_len_i(post_len), .axi_awvalid_i(awv), .axi_awready_i(awr),
        .axi_awaddr_i(awaddr), .axi_wvalid_i(wv), .axi_wready_i(wr),
        .axi_wstrb_i(wstrb), .smp_we_i(swe), .axi_cnt_o(axi_cnt), .smp_cnt_o(smp_cnt),
        .trig_cnt_o(trig_cnt), .trig_addr_o(trig_addr), .err_strb_o(err_strb),
        .err_cnt_o(err_cnt), .state_o(state), .done_o(done)
    );

    acq_wr_monitor #(.NUM_CH(1), .DW(64), .AW(32), .CW(4), .QUIET(4)) dut4 (
        .clk_i(clk), .rstn_i(rstn), .start_i(s4_start), .clear_i(1'b0), .trig_i(1'b0),
        .post_len_i(4'd0), .axi_awvalid_i(1'b0), .axi_awready_i(1'b0),
        .axi_awaddr_i(32'd0), .axi_wvalid_i(s4_wv), .axi_wready_i(s4_wv),
        .axi_wstrb_i(s4_strb), .smp_we_i(1'b0), .axi_cnt_o(a4_axi), .smp_cnt_o(a4_smp),
        .trig_cnt_o(a4_trig), .trig_addr_o(a4_taddr), .err_strb_o(a4_estrb),
        .err_cnt_o(a4_ecnt), .state_o(a4_state), .done_o(a4_done)
    );

    // ---------------- reference model ----------------
    int unsigned m_state, m_idle;
    longint      m_axi[NC], m_smp[NC], m_trig[NC];
    logic [31:0] m_addr[NC], m_taddr[NC];
    bit          m_estrb[NC], m_ecnt[NC];

    // Samples carried by a strobe, or -1 when it is not a contiguous even run of low ones.
    function automatic int lanes(logic [SW-1:0] s);
        int v = int'(s);
        int ones = $countones(s);
        if (((v + 1) & v) != 0) return -1;
        if ((ones % 2) != 0) return -1;
        return ones / 2;
    endfunction

    function automatic longint sat(longint v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_zero(bit with_addr);
        for (int c = 0; c < NC; c++) begin
            m_axi[c] = 0; m_smp[c] = 0; m_trig[c] = 0; m_taddr[c] = 0;
            m_estrb[c] = 0; m_ecnt[c] = 0;
            if (with_addr) m_addr[c] = 0;
        end
        m_idle = 0;
    endtask

    task automatic model_step();
        longint old0 = m_axi[0];
        bit anyb = 0;
        int k;
        for (int c = 0; c < NC; c++)
            if (awv[c] && awr[c]) m_addr[c] = awaddr[c*32 +: 32];
        if (clear) begin
            model_zero(1); m_state = 0; return;
        end
        if (m_state == 0 || m_state == 4) begin
            if (start) begin model_zero(0); m_state = 1; end
            return;
        end
        for (int c = 0; c < NC; c++) begin
            if (wv[c] && wr[c]) begin
                anyb = 1;
                k = lanes(wstrb[c*SW +: SW]);
                if (k < 0) m_estrb[c] = 1;
                else m_axi[c] = sat(m_axi[c] + k);
            end
            if (swe[c]) m_smp[c] = sat(m_smp[c] + 1);
        end
        case (m_state)
            1: if (trig) begin
                   for (int c = 0; c < NC; c++) begin m_trig[c] = m_axi[c]; m_taddr[c] = m_addr[c]; end
                   m_state = 2;
               end
            2: begin
                   m_idle = 0;
                   if (old0 - m_trig[0] >= longint'(post_len)) m_state = 3;
               end
            3: if (anyb) m_idle = 0;
               else begin
                   m_idle++;
                   if (m_idle == QT) begin
                       for (int c = 0; c < NC; c++) m_ecnt[c] = (m_axi[c] != m_smp[c]);
                       m_state = 4;
                   end
               end
            default: ;
        endcase
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic [63:0] ea, es, et, ed;
        for (int c = 0; c < NC; c++) begin
            ea[c*32 +: 32] = m_axi[c][31:0];
            es[c*32 +: 32] = m_smp[c][31:0];
            et[c*32 +: 32] = m_trig[c][31:0];
            ed[c*32 +: 32] = m_taddr[c];
        end
        chk("m_axi_cnt", axi_cnt, ea);
        chk("m_smp_cnt", smp_cnt, es);
        chk("m_trig_cnt", trig_cnt, et);
        chk("m_trig_addr", trig_addr, ed);
        chk("m_err_strb", {62'd0, err_strb}, {62'd0, m_estrb[1], m_estrb[0]});
        chk("m_err_cnt", {62'd0, err_cnt}, {62'd0, m_ecnt[1], m_ecnt[0]});
        chk("m_state", {61'd0, state}, 64'(m_state));
        chk("m_done", {63'd0, done}, {63'd0, m_state == 4});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        start = 0; clear = 0; trig = 0; awv = 0; awr = 0; wv = 0; wr = 0;
        swe = 0; wstrb = 0; awaddr = 0;
    endtask

    task automatic beat0(logic [7:0] s);
        wv = 2'b01; wr = 2'b01; wstrb = {8'h00, s};
    endtask

    // One capture on channel 0: preload n_smp source samples, then 28 AXI samples.
    task automatic run_capture(int n_smp, bit exp_err);
        idle_in(); clear = 1; tick();
        idle_in(); start = 1; post_len = 16; tick();
        idle_in(); chk("cap_armed", {61'd0, state}, 64'd1);
        repeat (n_smp) begin swe = 2'b01; tick(); end
        idle_in(); beat0(8'hFF); tick(); tick();
        idle_in(); chk("cap_axi8", axi_cnt[31:0], 64'd8);
        beat0(8'hFF); trig = 1; awv = 2'b01; awr = 2'b01; awaddr = 64'h1000; tick();
        idle_in();
        chk("trig_cnt", trig_cnt[31:0], 64'd12);
        chk("trig_addr", trig_addr[31:0], 64'h1000);
        chk("post_state", {61'd0, state}, 64'd2);
        repeat (4) begin beat0(8'hFF); tick(); end
        idle_in();
        chk("post_axi28", axi_cnt[31:0], 64'd28);
        chk("post_hold", {61'd0, state}, 64'd2);
        tick();
        chk("check_state", {61'd0, state}, 64'd3);
        repeat (QT - 1) tick();
        chk("check_before_quiet", {61'd0, state}, 64'd3);
        tick();
        chk("done_state", {61'd0, state}, 64'd4);
        chk("done_o", {63'd0, done}, 64'd1);
        chk("err_cnt", {62'd0, err_cnt}, {62'd0, 1'b0, exp_err});
        swe = 2'b01; beat0(8'hFF); tick(); idle_in();
        chk("done_hold_smp", smp_cnt[31:0], 64'(n_smp));
        chk("done_hold_axi", axi_cnt[31:0], 64'd28);
    endtask

    typedef struct {
        bit          start, clear, wv, wr;
        logic [7:0]  strb;
        logic [63:0] axi;
        bit          estrb;
        logic [2:0]  st;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mkv(bit s, bit c, bit v, bit r, logic [7:0] sb,
                                 logic [63:0] a, bit e, logic [2:0] st);
        vec_t t;
        t.start = s; t.clear = c; t.wv = v; t.wr = r; t.strb = sb;
        t.axi = a; t.estrb = e; t.st = st;
        return t;
    endfunction

    initial begin
        int seg_beat;
        idle_in(); post_len = 0; rstn = 0;
        s4_start = 0; s4_wv = 0; s4_strb = 0;
        model_zero(1); m_state = 0;
        #12;
        chk("rst_state", {61'd0, state}, 64'd0);
        chk("rst_axi", axi_cnt, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk); rstn = 1;

        // Directed table on channel 0.
        tbl.push_back(mkv(1, 0, 0, 0, 8'h00, 0, 0, 3'd1));
        for (int i = 1; i <= 10; i++) tbl.push_back(mkv(0, 0, 1, 1, 8'hFF, 64'(4 * i), 0, 3'd1));
        tbl.push_back(mkv(0, 1, 0, 0, 8'h00, 0, 0, 3'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 8'h00, 0, 0, 3'd1));
        tbl.push_back(mkv(0, 0, 1, 1, 8'h03, 1, 0, 3'd1));
        tbl.push_back(mkv(0, 0, 1, 1, 8'h0F, 3, 0, 3'd1));
        tbl.push_back(mkv(0, 0, 1, 1, 8'h3F, 6, 0, 3'd1));
        tbl.push_back(mkv(0, 0, 1, 0, 8'hFF, 6, 0, 3'd1));
        tbl.push_back(mkv(0, 0, 1, 1, 8'h00, 6, 0, 3'd1));
        tbl.push_back(mkv(0, 0, 1, 1, 8'h0C, 6, 1, 3'd1));
        tbl.push_back(mkv(0, 0, 0, 0, 8'h00, 6, 1, 3'd1));
        tbl.push_back(mkv(1, 0, 1, 1, 8'h03, 7, 1, 3'd1));
        for (int i = 0; i < tbl.size(); i++) begin
            idle_in();
            start = tbl[i].start; clear = tbl[i].clear;
            wv = {1'b0, tbl[i].wv}; wr = {1'b0, tbl[i].wr}; wstrb = {8'h00, tbl[i].strb};
            tick();
            chk($sformatf("tbl%0d_axi", i), axi_cnt[31:0], tbl[i].axi);
            chk($sformatf("tbl%0d_estrb", i), {63'd0, err_strb[0]}, {63'd0, tbl[i].estrb});
            chk($sformatf("tbl%0d_state", i), {61'd0, state}, {61'd0, tbl[i].st});
        end

        run_capture(28, 1'b0);
        run_capture(29, 1'b1);

        // Saturation on a 4-bit counter.
        s4_start = 1; tick(); s4_start = 0;
        chk("cw4_armed", {61'd0, a4_state}, 64'd1);
        s4_wv = 1; s4_strb = 8'hFF;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("cw4_beat%0d", i), {60'd0, a4_axi}, (i >= 4) ? 64'd15 : 64'(4 * i));
        end
        s4_wv = 0; s4_strb = 0;

        // Asynchronous reset during POST.
        idle_in(); clear = 1; tick();
        idle_in(); start = 1; post_len = 100; tick();
        idle_in(); beat0(8'hFF); swe = 2'b11; trig = 1; tick();
        idle_in(); beat0(8'hFF); tick(); idle_in();
        chk("pre_rst_post", {61'd0, state}, 64'd2);
        #2 rstn = 0; #1;
        model_zero(1); m_state = 0;
        chk("arst_state", {61'd0, state}, 64'd0);
        chk("arst_axi", axi_cnt, 64'd0);
        chk("arst_smp", smp_cnt, 64'd0);
        chk("arst_trig", trig_cnt, 64'd0);
        @(negedge clk); rstn = 1;
        tick();
        chk("arst_release_idle", {61'd0, state}, 64'd0);

        // post_len = 0 then clear inside CHECK.
        idle_in(); start = 1; post_len = 0; tick();
        idle_in(); trig = 1; tick();
        idle_in(); chk("pl0_post", {61'd0, state}, 64'd2);
        beat0(8'h3F); tick(); idle_in();
        chk("pl0_check", {61'd0, state}, 64'd3);
        clear = 1; tick(); idle_in();
        chk("clr_idle", {61'd0, state}, 64'd0);
        chk("clr_axi", axi_cnt, 64'd0);

        // Randomized run against the model.
        for (int seg = 0; seg < 8; seg++) begin
            seg_beat = (seg % 2 == 0) ? 50 : 3;
            for (int n = 0; n < 120; n++) begin
                idle_in();
                start    = ($urandom_range(99) < 6);
                clear    = ($urandom_range(299) == 0);
                trig     = ($urandom_range(99) < 5);
                post_len = $urandom_range(12);
                awv = 2'($urandom); awr = 2'($urandom);
                awaddr = {$urandom, $urandom};
                swe = 2'($urandom);
                for (int c = 0; c < NC; c++) begin
                    logic [7:0] legal [5];
                    legal = '{8'h00, 8'h03, 8'h0F, 8'h3F, 8'hFF};
                    wv[c] = ($urandom_range(99) < seg_beat);
                    wr[c] = ($urandom_range(99) < 80);
                    wstrb[c*SW +: SW] = ($urandom_range(99) < 85) ? legal[$urandom_range(4)] : 8'($urandom);
                end
                tick();
                chk_model();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acq_wr_monitor.md
ACQ_WR_MONITOR -- requirements
Module: acq_wr_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of monitored acquisition channels (1..4).
REQ-002 SHALL have parameter DW, default 64, AXI write-data width (64 or 128); sample lanes L = DW/16.
REQ-003 SHALL have parameter AW, default 32, AXI address width.
REQ-004 SHALL have parameter CW, default 32, counter width.
REQ-005 SHALL have parameter QUIET, default 16, idle cycles required before the count check.
REQ-006 SHALL have ports, one per line: name  direction  width  meaning
- clk_i  in  1  single clock; all inputs are synchronous to it
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: arm a capture
- clear_i  in  1  pulse: abort and clear everything
- trig_i  in  1  acquisition trigger pulse
- post_len_i  in  CW  post-trigger samples expected on channel 0
- axi_awvalid_i, axi_awready_i  in  NUM_CH  AW handshake per channel
- axi_awaddr_i  in  NUM_CH*AW  AW address per channel
- axi_wvalid_i, axi_wready_i  in  NUM_CH  W handshake per channel
- axi_wstrb_i  in  NUM_CH*DW/8  W strobes per channel
- smp_we_i  in  NUM_CH  source-side sample write enable (one sample per cycle)
- axi_cnt_o  out  NUM_CH*CW  samples accepted on AXI per channel
- smp_cnt_o  out  NUM_CH*CW  source samples per channel
- trig_cnt_o  out  NUM_CH*CW  axi_cnt snapshot at trigger
- trig_addr_o  out  NUM_CH*AW  last accepted AW address at trigger
- err_strb_o  out  NUM_CH  sticky illegal-strobe flag
- err_cnt_o  out  NUM_CH  mismatch flag, valid when done_o = 1
- state_o  out  3  current FSM state
- done_o  out  1  high in DONE

Function
REQ-007 SHALL implement the FSM states IDLE=0, ARMED=1, POST=2, CHECK=3, DONE=4, exposed on state_o.
REQ-008 SHALL apply clear_i above all other events: from any state, go to IDLE next cycle and zero every counter, snapshot and flag.
REQ-009 SHALL handle start_i in IDLE or DONE: zero counters, snapshots and flags, then go to ARMED; start_i SHALL be ignored in any other state.
REQ-010 SHALL increment counters only in ARMED, POST and CHECK states.
REQ-011 SHALL treat a W beat on channel c as accepted when axi_wvalid_i[c] & axi_wready_i[c] = 1.
REQ-012 SHALL decode strobes per 16-bit lane pair: a legal strobe has its low 2k bits set and the rest clear, k = 0..L; the beat then adds k to axi_cnt.
REQ-013 SHALL, on an illegal strobe on an accepted beat, add 0 to axi_cnt and set err_strb_o[c].
REQ-014 SHALL increment smp_cnt[c] by 1 per cycle with smp_we_i[c] = 1.
REQ-015 SHALL saturate all counters at 2^CW-1 and never wrap.
REQ-016 SHALL latch the AW address per channel on every accepted AW handshake (axi_awvalid_i & axi_awready_i), in any state.
REQ-017 SHALL, on trig_i in ARMED, go to POST and capture trig_cnt and trig_addr.
REQ-018 SHALL include in the trig_cnt snapshot any beat accepted in the same cycle as trig_i (post-update value).
REQ-019 SHALL, in the same cycle as trig_i, capture trig_addr including any AW handshake accepted in that cycle.
REQ-020 SHALL ignore trig_i outside ARMED.
REQ-021 SHALL, in POST, leave to CHECK when (axi_cnt[0] - trig_cnt[0]) >= post_len_i.
REQ-022 SHALL, when post_len_i = 0, go from POST to CHECK on the cycle after the trigger.
REQ-023 SHALL, in CHECK, count consecutive cycles with no accepted beat on any channel.
REQ-024 SHALL reset the CHECK idle counter on any accepted beat.
REQ-025 SHALL, when the idle counter reaches QUIET, set err_cnt_o[c] = (axi_cnt[c] != smp_cnt[c]) and go to DONE.
REQ-026 SHALL hold all counters and flags in DONE until start_i or clear_i.
REQ-027 SHALL drive all outputs directly from registers, with a single-cycle update latency from the input event.
REQ-028 SHALL tie channels >= NUM_CH to nothing: no ports and no logic for them.

Reset
REQ-029 SHALL, on rstn_i low, asynchronously force state IDLE and zero all counters, snapshots, address latches, flags, done_o and the idle counter.
REQ-030 SHALL, on rstn_i low mid-capture, abort the capture with no residual state; the first edge after release is in IDLE.

Verification
REQ-031 SHALL cover: start; 10 beats with strobe 0xFF on channel 0 -> axi_cnt[0] = 40.
REQ-032 SHALL cover: strobes 0x03, 0x0F, 0x3F on one channel, one beat each -> +1, +2, +3 (total 6); then strobe 0x0C -> count unchanged, err_strb_o = 1 sticky.
REQ-033 SHALL cover: trig_i coincident with a 0xFF beat at axi_cnt = 8 -> trig_cnt = 12; AW 0x1000 in the same cycle -> trig_addr = 0x1000.
REQ-034 SHALL cover: post_len_i = 16, four 0xFF beats after trigger -> CHECK; QUIET idle cycles -> DONE; smp_cnt = axi_cnt -> err_cnt = 0; one extra smp_we_i pulse -> err_cnt = 1.
REQ-035 SHALL cover: CW = 4, 5 beats with 0xFF -> counter holds 15, no wrap.
REQ-036 SHALL cover: rstn_i low during POST with counts nonzero -> all outputs 0 immediately, state_o = 0; clear_i in CHECK -> IDLE next cycle.
